// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation engine.
// Each clock applies ROUNDS_PER_CYCLE rounds (p_C -> p_S -> p_L) to a 320-bit state.
// A job runs 12, 8 or 6 rounds; the round constant index always ends at 11.
// Optional feature macro: ASCON_PERM_ABORT_EN adds abort_i to cancel a running job.
module ascon_permutation_iter #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned RND_W            = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [1:0]       nb_rounds_i,
  input  logic [319:0]     state_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             valid_o,
  output logic [319:0]     state_o,
  output logic [RND_W-1:0] round_o
);

  // x0 occupies the most significant 64 bits of the flat state
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  if ((ROUNDS_PER_CYCLE != 1) && (ROUNDS_PER_CYCLE != 2)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1 or 2");
  end

  if (RND_W < 4) begin : g_bad_rnd_w
    $error("RND_W must be at least 4");
  end

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Constant addition: only the low byte of x2 is touched
  function automatic type_state p_c(input type_state s, input logic [3:0] idx);
    type_state o;
    o = s;
    o.x2[7:0] = s.x2[7:0] ^ {4'hF - idx, idx};
    return o;
  endfunction

  // Bitsliced 5-bit S-box applied to all 64 columns at once
  function automatic type_state p_s(input type_state s);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    type_state   o;
    a0 = s.x0 ^ s.x4;
    a1 = s.x1;
    a2 = s.x2 ^ s.x1;
    a3 = s.x3;
    a4 = s.x4 ^ s.x3;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    o.x0 = a0;
    o.x1 = a1;
    o.x2 = a2;
    o.x3 = a3;
    o.x4 = a4;
    return o;
  endfunction

  // Linear diffusion: each word XORed with two rotations of itself
  function automatic type_state p_l(input type_state s);
    type_state o;
    o.x0 = s.x0 ^ ror64(s.x0, 19) ^ ror64(s.x0, 28);
    o.x1 = s.x1 ^ ror64(s.x1, 61) ^ ror64(s.x1, 39);
    o.x2 = s.x2 ^ ror64(s.x2, 1)  ^ ror64(s.x2, 6);
    o.x3 = s.x3 ^ ror64(s.x3, 10) ^ ror64(s.x3, 17);
    o.x4 = s.x4 ^ ror64(s.x4, 7)  ^ ror64(s.x4, 41);
    return o;
  endfunction

  function automatic type_state ascon_round(input type_state s, input logic [3:0] idx);
    return p_l(p_s(p_c(s, idx)));
  endfunction

  fsm_e             fsm_q, fsm_d;
  type_state        state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;

  logic             load;
  logic             abort;
  logic [RND_W-1:0] start_idx;
  logic [RND_W-1:0] base_idx;
  logic [RND_W-1:0] last_idx;
  logic [RND_W-1:0] ci;
  type_state        chain;

`ifdef ASCON_PERM_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // A new job is accepted whenever the engine is not mid-job
  assign load = start_i && (fsm_q != StRun);

  // First constant index is 12 - N; reserved encoding runs the full 12 rounds
  always_comb begin
    start_idx = '0;
    unique case (nb_rounds_i)
      2'd1:    start_idx = RND_W'(4);
      2'd2:    start_idx = RND_W'(6);
      default: start_idx = '0;
    endcase
  end

  assign base_idx = load ? start_idx : (round_q + RND_W'(1));
  assign last_idx = base_idx + RND_W'(ROUNDS_PER_CYCLE - 1);

  // Rounds of one iteration, chained combinationally
  always_comb begin
    chain = load ? type_state'(state_i) : state_q;
    ci    = base_idx;
    for (int r = 0; r < int'(ROUNDS_PER_CYCLE); r++) begin
      chain = ascon_round(chain, ci[3:0]);
      ci    = ci + RND_W'(1);
    end
  end

  // Next-state logic; completion is detected by the last round index reaching 11
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    unique case (fsm_q)
      StIdle, StDone: begin
        if (load) begin
          state_d = chain;
          round_d = last_idx;
          fsm_d   = StRun;
        end else begin
          fsm_d = StIdle;
        end
      end
      StRun: begin
        if (abort) begin
          fsm_d = StIdle;
        end else begin
          state_d = chain;
          round_d = last_idx;
          if (last_idx == RND_W'(11)) begin
            fsm_d = StDone;
          end
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign busy_o  = (fsm_q == StRun);
  assign valid_o = (fsm_q == StDone);
  assign state_o = state_q;
  assign round_o = round_q;

endmodule
